// File: rtl/sram_mem_ctrl.sv
// sram_mem_ctrl: MEM-stage load/store controller over a narrow multi-cycle SRAM (BEATS beats of WAIT+1 cycles each, ready freezes the pipeline); pipeline side clk, rst (sync active-low), rd_en, wr_en, address, write_data, read_data, ready; SRAM side sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_dq_in; define SRAM_WRITE_BUFFER_EN for posted writes
module sram_mem_ctrl #(
  parameter int DATA_W      = 32,
  parameter int SRAM_DATA_W = 16,
  parameter int SRAM_ADDR_W = 18,
  parameter int WAIT        = 2,
  parameter int BASE_ADDR   = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [DATA_W-1:0]      write_data,
  output logic [DATA_W-1:0]      read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_dq_out,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n,
  input  logic [SRAM_DATA_W-1:0] sram_dq_in
);
  localparam int BEATS = DATA_W / SRAM_DATA_W;
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int SH = $clog2(DATA_W / 8);
`ifdef SRAM_WRITE_BUFFER_EN
  localparam bit POST = 1'b1;
`else
  localparam bit POST = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t r_state;
  logic [BW-1:0] r_beat;
  logic [3:0] r_wait;
  logic r_wr, r_we_n, r_oe;
  logic [DATA_W-1:0] r_wdata, r_rbuf, r_read_data;
  logic [SRAM_ADDR_W-1:0] r_sram_addr;
  logic [SRAM_DATA_W-1:0] r_dq_out;
  logic [31:0] w_widx;
  logic [SRAM_ADDR_W-1:0] w_baddr;
  logic [DATA_W-1:0] w_wshift, w_rnext;
  logic w_last;
  assign w_widx = (address - 32'(BASE_ADDR)) >> SH;
  assign w_baddr = SRAM_ADDR_W'(w_widx * 32'(BEATS));
  assign w_wshift = r_wdata >> SRAM_DATA_W;
  assign w_rnext = DATA_W'({sram_dq_in, r_rbuf} >> SRAM_DATA_W);
  assign w_last = r_beat == BW'(BEATS - 1);
  assign ready = !rst || !(rd_en || wr_en) || r_state == DONE || (POST && wr_en && r_state == IDLE);
  assign read_data = r_read_data;
  assign sram_addr = r_sram_addr;
  assign sram_dq_out = r_dq_out;
  assign sram_dq_oe = r_oe;
  assign sram_we_n = r_we_n;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_beat <= '0;
      r_wait <= '0;
      r_wr <= 1'b0;
      r_wdata <= '0;
      r_rbuf <= '0;
      r_read_data <= '0;
      r_sram_addr <= '0;
      r_dq_out <= '0;
      r_we_n <= 1'b1;
      r_oe <= 1'b0;
    end else if (r_state == IDLE && (rd_en || wr_en)) begin
      r_state <= ACCESS;
      r_wr <= wr_en;
      r_beat <= '0;
      r_wait <= 4'(WAIT);
      r_sram_addr <= w_baddr;
      r_wdata <= write_data;
      r_dq_out <= write_data[SRAM_DATA_W-1:0];
      r_we_n <= !wr_en;
      r_oe <= wr_en;
    end else if (r_state == ACCESS) begin
      if (r_wait != 4'd0) begin
        r_wait <= r_wait - 4'd1;
      end else begin
        if (!r_wr) r_rbuf <= w_rnext;
        if (w_last) begin
          r_state <= (POST && r_wr) ? IDLE : DONE;
          r_we_n <= 1'b1;
          r_oe <= 1'b0;
          if (!r_wr) r_read_data <= w_rnext;
        end else begin
          r_beat <= r_beat + 1'b1;
          r_wait <= 4'(WAIT);
          r_sram_addr <= r_sram_addr + 1'b1;
          r_wdata <= w_wshift;
          r_dq_out <= w_wshift[SRAM_DATA_W-1:0];
        end
      end
    end else if (r_state == DONE) begin
      r_state <= IDLE;
    end
  end
endmodule

// File: tb/tb_sram_mem_ctrl.sv
// tb_sram_mem_ctrl: randomized self-checking bench for sram_mem_ctrl against a word-level memory and timing model
module tb_sram_mem_ctrl;
  localparam int W = 2;
  localparam int BEATS = 2;
  localparam int L = BEATS * (W + 1) + 1;
  localparam int D = BEATS * (W + 1);
`ifdef SRAM_WRITE_BUFFER_EN
  localparam bit POST = 1'b1;
`else
  localparam bit POST = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0, rd_en = 1'b0, wr_en = 1'b0, rd_w = 1'b0;
  logic [31:0] address = 32'd0, write_data = 32'd0;
  logic [31:0] read_data, rd0, rd5;
  logic ready, ready0, ready5, sram_dq_oe, sram_we_n, oe0, oe5, we0, we5;
  logic [17:0] sram_addr, a0, a5;
  logic [15:0] sram_dq_out, sram_dq_in, o0, o5;
  logic [15:0] mem [0:262143];
  logic [31:0] ref_mem [int];
  logic [34:0] wq [$];
  int checks = 0, errors = 0, cyc = 0, free_at = 0;
  logic [31:0] last_rd = 32'd0;

  sram_mem_ctrl dut (.clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready), .sram_addr(sram_addr),
    .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n), .sram_dq_in(sram_dq_in));
  sram_mem_ctrl #(.WAIT(0)) dut_w0 (.clk(clk), .rst(rst), .rd_en(rd_w), .wr_en(1'b0), .address(address),
    .write_data(write_data), .read_data(rd0), .ready(ready0), .sram_addr(a0),
    .sram_dq_out(o0), .sram_dq_oe(oe0), .sram_we_n(we0), .sram_dq_in(a0[15:0] ^ 16'h5A5A));
  sram_mem_ctrl #(.WAIT(5)) dut_w5 (.clk(clk), .rst(rst), .rd_en(rd_w), .wr_en(1'b0), .address(address),
    .write_data(write_data), .read_data(rd5), .ready(ready5), .sram_addr(a5),
    .sram_dq_out(o5), .sram_dq_oe(oe5), .sram_we_n(we5), .sram_dq_in(a5[15:0] ^ 16'h5A5A));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (!sram_we_n) mem[sram_addr] <= sram_dq_out;
  assign sram_dq_in = mem[sram_addr];
  always @(negedge clk) if (!sram_we_n) wq.push_back({sram_dq_oe, sram_addr, sram_dq_out});

  function automatic int key(input logic [31:0] a);
    return int'(((a - 32'd1024) >> 2) & 32'h1FFFF);
  endfunction

  task automatic run(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                     output int lat, output int el, output logic [31:0] got, output logic [31:0] erd);
    int start;
    start = (free_at > cyc) ? free_at : cyc;
    if (wr && POST) begin
      el = start - cyc;
      free_at = start + 1 + D;
    end else begin
      el = start + L - cyc;
      free_at = start + L + 1;
    end
    if (wr) ref_mem[key(a)] = d;
    else last_rd = ref_mem.exists(key(a)) ? ref_mem[key(a)] : 32'd0;
    erd = last_rd;
    rd_en = rd; wr_en = wr; address = a; write_data = d;
    lat = 0;
    @(negedge clk);
    while (!ready && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    got = read_data;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    rd_en = 1'b0; wr_en = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; rd_en = 1'b1; address = 32'd1028;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks += 4;
      if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready cyc%0d got %b expected 1", i, ready); end
      if (sram_we_n !== 1'b1) begin errors++; $display("FAIL reset_we_n cyc%0d got %b expected 1", i, sram_we_n); end
      if (sram_dq_oe !== 1'b0) begin errors++; $display("FAIL reset_oe cyc%0d got %b expected 0", i, sram_dq_oe); end
      if (read_data !== 32'd0) begin errors++; $display("FAIL reset_rdata cyc%0d got %h expected 0", i, read_data); end
    end
    @(posedge clk); #1;
    rst = 1'b1; rd_en = 1'b0;
    free_at = 0;
    idle(1);
  endtask

  task automatic test_store_load();
    int lat, el;
    logic [31:0] got, erd;
    logic [34:0] e;
    wq.delete();
    run(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, lat, el, got, erd);
    checks++;
    if (lat != el) begin errors++; $display("FAIL store_latency got %0d expected %0d", lat, el); end
    run(1'b1, 1'b0, 32'd1028, 32'd0, lat, el, got, erd);
    checks += 3;
    if (lat != el) begin errors++; $display("FAIL load_latency got %0d expected %0d", lat, el); end
    if (got !== 32'hDEADBEEF) begin errors++; $display("FAIL load_data got %h expected deadbeef", got); end
    if (wq.size() != D) begin errors++; $display("FAIL store_beat_count got %0d expected %0d", wq.size(), D); end
    for (int i = 0; i < wq.size() && i < D; i++) begin
      e = {1'b1, 18'(2 + i / (W + 1)), (i / (W + 1)) == 0 ? 16'hBEEF : 16'hDEAD};
      checks++;
      if (wq[i] !== e) begin errors++; $display("FAIL store_beat%0d got %h expected %h", i, wq[i], e); end
    end
    idle(1);
  endtask

  task automatic test_both();
    int lat, el;
    logic [31:0] got, erd;
    wq.delete();
    run(1'b1, 1'b1, 32'd1032, 32'h12345678, lat, el, got, erd);
    checks += 2;
    if (lat != el) begin errors++; $display("FAIL both_latency got %0d expected %0d", lat, el); end
    if (got !== erd) begin errors++; $display("FAIL both_rdata_hold got %h expected %h", got, erd); end
    run(1'b1, 1'b0, 32'd1032, 32'd0, lat, el, got, erd);
    checks += 3;
    if (lat != el) begin errors++; $display("FAIL both_read_latency got %0d expected %0d", lat, el); end
    if (got !== 32'h12345678) begin errors++; $display("FAIL both_read_data got %h expected 12345678", got); end
    if (wq.size() != D) begin errors++; $display("FAIL both_write_beats got %0d expected %0d", wq.size(), D); end
    idle(1);
  endtask

  task automatic test_wait_states();
    int l0, l5;
    logic [31:0] d0, d5, e;
    e = {16'h0001 ^ 16'h5A5A, 16'h0000 ^ 16'h5A5A};
    l0 = -1; l5 = -1; d0 = 32'd0; d5 = 32'd0;
    address = 32'd1024; rd_w = 1'b1;
    for (int n = 0; n < 40 && (l0 < 0 || l5 < 0); n++) begin
      @(negedge clk);
      if (ready0 && l0 < 0) begin l0 = n; d0 = rd0; end
      if (ready5 && l5 < 0) begin l5 = n; d5 = rd5; end
    end
    @(posedge clk); #1;
    rd_w = 1'b0;
    checks += 4;
    if (l0 != 3) begin errors++; $display("FAIL wait0_latency got %0d expected 3", l0); end
    if (l5 != 13) begin errors++; $display("FAIL wait5_latency got %0d expected 13", l5); end
    if (d0 !== e) begin errors++; $display("FAIL wait0_data got %h expected %h", d0, e); end
    if (d5 !== e) begin errors++; $display("FAIL wait5_data got %h expected %h", d5, e); end
    idle(20);
  endtask

  task automatic test_random();
    int lat, el, op;
    logic [31:0] got, erd, a, d;
    for (int i = 0; i < 60; i++) begin
      op = int'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: a = 32'd1020 - 32'd4 * $urandom_range(0, 3);
        1: a = 32'd1024 + 32'd4 * (32'h20000 + $urandom_range(0, 15));
        default: a = 32'd1024 + 32'd4 * $urandom_range(0, 15);
      endcase
      d = $urandom;
      run(op != 1, op == 1 || op == 2, a, d, lat, el, got, erd);
      checks += 2;
      if (lat != el) begin errors++; $display("FAIL rand%0d_latency addr=%h got %0d expected %0d", i, a, lat, el); end
      if (got !== erd) begin errors++; $display("FAIL rand%0d_rdata addr=%h got %h expected %h", i, a, got, erd); end
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(20);
  endtask

  task automatic test_reset_mid();
    int lat, el;
    logic [31:0] got, erd;
    rd_en = 1'b1; wr_en = 1'b0; address = 32'd1028;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL midreset_ready got %b expected 1", ready); end
    @(posedge clk); #1;
    checks += 3;
    if (read_data !== 32'd0) begin errors++; $display("FAIL midreset_rdata got %h expected 0", read_data); end
    if (sram_we_n !== 1'b1) begin errors++; $display("FAIL midreset_we_n got %b expected 1", sram_we_n); end
    if (sram_dq_oe !== 1'b0) begin errors++; $display("FAIL midreset_oe got %b expected 0", sram_dq_oe); end
    rst = 1'b1; free_at = 0; last_rd = 32'd0;
    run(1'b1, 1'b0, 32'd1028, 32'd0, lat, el, got, erd);
    checks += 2;
    if (lat != el) begin errors++; $display("FAIL reissue_latency got %0d expected %0d", lat, el); end
    if (got !== erd) begin errors++; $display("FAIL reissue_data got %h expected %h", got, erd); end
    idle(2);
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) mem[i] = 16'h0000;
    test_reset();
    test_store_load();
    test_both();
    test_wait_states();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
